// File: rtl/gpi_debounce.sv
// Switch input conditioning: active-low pins are synchronised into clk_sys,
// debounced per bit, and turned into levels, edge pulses, sticky flags and an irq.

// One switch bit: two-flop synchroniser, persistence counter, edge and sticky logic.
module gpi_debounce_bit #(
  parameter int unsigned DebounceCycles = 300000,
  parameter int unsigned CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic clk_sys,
  input  logic rst_sys_n,
  input  logic pin_n,
  input  logic clr,
  output logic state,
  output logic rise,
  output logic fall,
  output logic pressed
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  // sync_q[0] is stage1, sync_q[1] is stage2; both idle at released (1).
  logic [1:0]          sync_q;
  logic                sync;
  logic                stable_q;
  logic [CntWidth-1:0] cnt_q;
  logic                accept;
  logic                rise_pending;
  logic                fall_pending;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], pin_n};
  end

  assign sync         = ~sync_q[1];
  assign accept       = (sync != stable_q) && (cnt_q == CntMax);
  assign rise_pending = accept &  sync;
  assign fall_pending = accept & ~sync;

  // Any return to the stable level before acceptance restarts the count from 0.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sync == stable_q) begin
      cnt_q    <= '0;
    end else if (accept) begin
      stable_q <= sync;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + CntWidth'(1);
    end
  end

  // Edge pulses register alongside stable so they line up with the new level.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rise    <= 1'b0;
      fall    <= 1'b0;
      pressed <= 1'b0;
    end else begin
      rise    <= rise_pending;
      fall    <= fall_pending;
      pressed <= rise_pending | (pressed & ~clr);
    end
  end

  assign state = stable_q;

endmodule

module gpi_debounce #(
  parameter int unsigned Width          = 13,
  parameter int unsigned DebounceCycles = 300000,
  parameter int unsigned CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic [Width-1:0] pins_ni,
  output logic [Width-1:0] state_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] pressed_o,
  input  logic [Width-1:0] clr_i,
  input  logic [Width-1:0] irq_en_i,
  output logic             irq_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpi_debounce_bit #(
      .DebounceCycles (DebounceCycles),
      .CntWidth       (CntWidth)
    ) u_bit (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .pin_n     (pins_ni[i]),
      .clr       (clr_i[i]),
      .state     (state_o[i]),
      .rise      (rise_o[i]),
      .fall      (fall_o[i]),
      .pressed   (pressed_o[i])
    );
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) irq_o <= 1'b0;
    else            irq_o <= |(pressed_o & irq_en_i);
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce with DebounceCycles=4: per-cycle vector table
// plus hand sequences for reset release, bounce, set/clear collision, mid-count reset.
module tb_gpi_debounce;

  localparam int W = 13;
  localparam logic [W-1:0] ALL = 13'h1fff;
  localparam logic [W-1:0] M6  = 13'h0040;
  localparam logic [W-1:0] G3  = 13'h0008;
  localparam logic [W-1:0] B12 = 13'h1000;

  logic         clk_sys = 1'b0;
  logic         rst_sys_n = 1'b0;
  logic [W-1:0] pins_ni = '0;
  logic [W-1:0] clr_i = '0;
  logic [W-1:0] irq_en_i = '0;
  logic [W-1:0] state_o, rise_o, fall_o, pressed_o;
  logic         irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] pins, clr, en;
    logic [W-1:0] st, ri, fa, pr;
    logic         irq;
  } vec_t;
  vec_t tbl[$];

  gpi_debounce #(.Width(W), .DebounceCycles(4)) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .pins_ni   (pins_ni),
    .state_o   (state_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .pressed_o (pressed_o),
    .clr_i     (clr_i),
    .irq_en_i  (irq_en_i),
    .irq_o     (irq_o)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, take one posedge, return at the next negedge.
  task automatic step(input logic [W-1:0] p, input logic [W-1:0] c, input logic [W-1:0] e);
    pins_ni  = p;
    clr_i    = c;
    irq_en_i = e;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic add(input int n, input logic [W-1:0] p, input logic [W-1:0] c,
                     input logic [W-1:0] e, input logic [W-1:0] st, input logic [W-1:0] ri,
                     input logic [W-1:0] fa, input logic [W-1:0] pr, input logic irq);
    vec_t v;
    v.pins = p; v.clr = c; v.en = e;
    v.st = st; v.ri = ri; v.fa = fa; v.pr = pr; v.irq = irq;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    int rise_cnt;
    int rise_at;

    // Press/release on bit 6 with irq enabled, then clear.
    add(5, ALL ^ M6, '0, M6, '0, '0, '0, '0, 1'b0);
    add(1, ALL ^ M6, '0, M6, M6, M6, '0, M6, 1'b0);
    add(2, ALL ^ M6, '0, M6, M6, '0, '0, M6, 1'b1);
    add(5, ALL,      '0, M6, M6, '0, '0, M6, 1'b1);
    add(1, ALL,      '0, M6, '0, '0, M6, M6, 1'b1);
    add(1, ALL,      '0, M6, '0, '0, '0, M6, 1'b1);
    add(1, ALL,      M6, M6, '0, '0, '0, '0, 1'b1);
    add(1, ALL,      '0, M6, '0, '0, '0, '0, 1'b0);
    // Bit 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    add(3, ALL ^ G3, '0, '0, '0, '0, '0, '0, 1'b0);
    add(6, ALL,      '0, '0, '0, '0, '0, '0, 1'b0);
    add(4, ALL ^ G3, '0, '0, '0, '0, '0, '0, 1'b0);
    add(1, ALL,      '0, '0, '0, '0, '0, '0, 1'b0);
    add(1, ALL,      '0, '0, G3, G3, '0, G3, 1'b0);
    add(3, ALL,      '0, '0, G3, '0, '0, G3, 1'b0);
    add(1, ALL,      '0, '0, '0, '0, G3, G3, 1'b0);
    add(1, ALL,      '0, '0, '0, '0, '0, G3, 1'b0);

    // Reset held with all pins pressed.
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    pins_ni   = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_state",   32'(state_o),   32'h0);
    chk("rst_rise",    32'(rise_o),    32'h0);
    chk("rst_fall",    32'(fall_o),    32'h0);
    chk("rst_pressed", 32'(pressed_o), 32'h0);
    chk("rst_irq",     32'(irq_o),     32'h0);
    rst_sys_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step('0, '0, '0);
      if (k <= 5) chk($sformatf("rel_state_e%0d", k), 32'(state_o), 32'h0);
      if (k == 6) begin
        chk("rel_state_e6",   32'(state_o),   32'(ALL));
        chk("rel_rise_e6",    32'(rise_o),    32'(ALL));
        chk("rel_pressed_e6", 32'(pressed_o), 32'(ALL));
      end
      if (k == 7) begin
        chk("rel_rise_e7",    32'(rise_o),    32'h0);
        chk("rel_pressed_e7", 32'(pressed_o), 32'(ALL));
      end
    end

    // Clean reset with pins released before the table.
    rst_sys_n = 1'b0;
    step(ALL, '0, '0);
    step(ALL, '0, '0);
    rst_sys_n = 1'b1;
    step(ALL, '0, '0);

    foreach (tbl[i]) begin
      step(tbl[i].pins, tbl[i].clr, tbl[i].en);
      chk($sformatf("row%0d_state", i),   32'(state_o),   32'(tbl[i].st));
      chk($sformatf("row%0d_rise", i),    32'(rise_o),    32'(tbl[i].ri));
      chk($sformatf("row%0d_fall", i),    32'(fall_o),    32'(tbl[i].fa));
      chk($sformatf("row%0d_pressed", i), 32'(pressed_o), 32'(tbl[i].pr));
      chk($sformatf("row%0d_irq", i),     32'(irq_o),     32'(tbl[i].irq));
    end

    // Bounce on bit 12: one rise, six cycles after the final transition.
    rise_cnt = 0;
    rise_at  = -1;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        step((j < 2) ? (ALL ^ B12) : ALL, '0, '0);
        if (rise_o[12]) rise_cnt++;
      end
    end
    for (int j = 0; j < 12; j++) begin
      step(ALL ^ B12, '0, '0);
      if (rise_o[12]) begin
        rise_cnt++;
        if (rise_at < 0) rise_at = j;
      end
    end
    chk("bounce_rise_count", 32'(rise_cnt), 32'd1);
    chk("bounce_rise_step",  32'(rise_at),  32'd5);
    chk("bounce_state",      32'(state_o[12]), 32'd1);
    repeat (8) step(ALL, '0, '0);
    chk("bounce_released", 32'(state_o[12]), 32'd0);

    // Clear on bit 0 coincides with the rise: set wins.
    for (int j = 0; j < 6; j++) step(ALL ^ 13'h1, (j == 5) ? 13'h1 : 13'h0, 13'h1);
    chk("coll_rise",    32'(rise_o[0]),    32'd1);
    chk("coll_pressed", 32'(pressed_o[0]), 32'd1);
    step(ALL ^ 13'h1, '0, 13'h1);
    chk("coll_irq_set",     32'(irq_o),        32'd1);
    chk("coll_pressed_hold", 32'(pressed_o[0]), 32'd1);
    step(ALL ^ 13'h1, '0, 13'h1);
    step(ALL ^ 13'h1, 13'h1, 13'h1);
    chk("clr_pressed",  32'(pressed_o[0]), 32'd0);
    chk("clr_irq_lag",  32'(irq_o),        32'd1);
    step(ALL ^ 13'h1, '0, 13'h1);
    chk("clr_irq_drop", 32'(irq_o),        32'd0);

    // Reset with bit 1 mid-count discards the count.
    repeat (4) step(ALL ^ 13'h2, '0, '0);
    rst_sys_n = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("midrst_state",   32'(state_o),   32'h0);
    chk("midrst_pressed", 32'(pressed_o), 32'h0);
    chk("midrst_irq",     32'(irq_o),     32'h0);
    rst_sys_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(ALL ^ 13'h2, '0, '0);
      if (j == 4) chk("midrst_state_e5", 32'(state_o[1]), 32'd0);
      if (j == 5) begin
        chk("midrst_state_e6", 32'(state_o[1]), 32'd1);
        chk("midrst_rise_e6",  32'(rise_o[1]),  32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
Input conditioning stage directly upstream of the sonata_system general-purpose input bus. It synchronises the raw, active-low navigation and DIP switch pins into clk_sys and debounces each bit independently. It produces clean active-high levels for gp_i, plus per-bit edge pulses and sticky press flags with an interrupt request. It replaces the bare pin inversion currently done at the top level.

Parameters:
Width, 13, number of switch bits (5 nav + 8 user).
DebounceCycles, 300000, consecutive clk_sys cycles a changed level must persist before it is accepted (10 ms at 30 MHz); legal range >= 1.
CntWidth, $clog2(DebounceCycles+1), derived width of the per-bit counters; not to be overridden.

Ports:
clk_sys  input  1  system clock.
rst_sys_n  input  1  reset; asynchronous, active-low.
pins_ni  input  Width  raw switch pins, asynchronous, active-low (pulled up, 0 = pressed).
state_o  output  Width  debounced level, active-high (1 = pressed); drives gp_i.
rise_o  output  Width  one-cycle pulse per bit on accepted press.
fall_o  output  Width  one-cycle pulse per bit on accepted release.
pressed_o  output  Width  sticky flag per bit, set on rise, held until cleared.
clr_i  input  Width  per-bit clear strobe for pressed_o.
irq_en_i  input  Width  per-bit interrupt enable.
irq_o  output  1  OR of (pressed_o & irq_en_i), registered.

Behaviour:
- Reset: both synchroniser stages = all-ones (released); stable register = 0; counters = 0; state_o, rise_o, fall_o, pressed_o = 0; irq_o = 0. Reset asserted mid-count discards the count; on release every bit starts from released.
- Sync: two-flop synchroniser per bit on pins_ni; sync = ~stage2 (active-high). No other logic on stage1.
- Per-bit debounce: if sync == stable, counter <= 0. Otherwise, if counter == DebounceCycles-1, then stable <= sync and counter <= 0; else counter <= counter+1.
- Any glitch returning to the stable value before acceptance resets the counter to 0; there is no partial credit.
- Counter never exceeds DebounceCycles-1; no wrap.
- Latency: a pin change sampled at edge 0 appears on sync after edge 2 and on state_o after edge 2+DebounceCycles. With DebounceCycles=1, state_o follows sync one cycle later.
- state_o = stable (registered, no combinational path from pins).
- Edges: rise_o[i] = 1 for exactly the cycle after stable[i] goes 0->1, aligned with the first cycle state_o[i] = 1; fall_o likewise for 1->0. rise_o and fall_o are never both high on one bit. Consecutive accepted changes are at least DebounceCycles apart.
- Sticky: pressed_o[i] <= rise_pending[i] | (pressed_o[i] & ~clr_i[i]), where rise_pending is the stable 0->1 event that causes rise_o. Set wins over a simultaneous clear. clr_i on an already-clear bit has no effect. Release does not clear the flag.
- irq_o: registered; asserts the cycle after pressed_o & irq_en_i becomes nonzero, deasserts the cycle after it becomes zero. Changing irq_en_i does not alter pressed_o.
- Bits are fully independent; simultaneous changes on multiple bits each follow the rules above.

Test Plan:
- Reset (DebounceCycles=4): hold rst_sys_n low with pins_ni=0 -> all outputs 0. Release reset with pins_ni held 0 -> state_o[0] rises exactly 2+4 cycles after the first sampling edge, rise_o[0] pulses once, pressed_o[0]=1.
- Clean press/release, bit 6: pins_ni[6] 1->0 -> state_o[6]=1 at edge 6 with rise_o[6] for 1 cycle. Later 0->1 -> fall_o[6] pulse, state_o[6]=0, pressed_o[6] stays 1.
- Glitch rejection: pulse pins_ni[3] low for 3 cycles (< 4) -> state_o, rise_o, pressed_o unchanged. Pulse for exactly 4 post-sync cycles -> accepted.
- Bounce: toggle pins_ni[12] 0/1 every 2 cycles for 20 cycles, then hold 0 -> exactly one rise_o[12], 6 cycles after the final transition.
- Set/clear collision: irq_en_i[0]=1, clr_i[0] asserted in the same cycle as rise_o[0] generation -> pressed_o[0]=1, irq_o=1 next cycle. A subsequent lone clr_i[0] -> pressed_o[0]=0, irq_o=0 one cycle later.
- Reset mid-count: counter at 2 on bit 1, pulse rst_sys_n low -> counter 0, state_o[1]=0. Full 2+4 cycles are needed after release.
